// File: rtl/ghost_pkg.sv
// Shared sprite-mover definitions: orientation codes common with the map renderer,
// mover FSM state encoding and the sprite-code builder.
package ghost_pkg;

  localparam logic [2:0] ORIENT_RIGHT  = 3'b000;
  localparam logic [2:0] ORIENT_UP     = 3'b001;
  localparam logic [2:0] ORIENT_DOWN   = 3'b010;
  localparam logic [2:0] ORIENT_LEFT   = 3'b011;
  localparam logic [2:0] ORIENT_MIRROR = 3'b100;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_PROBE = 3'd2;
  localparam logic [2:0] ST_ERASE = 3'd3;
  localparam logic [2:0] ST_TURN  = 3'd4;
  localparam logic [2:0] ST_DRAW  = 3'd5;

  // Ghosts never mirror, so the mirror bit is forced clear in the drawn code.
  function automatic logic [7:0] sprite_code(input logic [2:0] orient, input logic [4:0] id);
    return {orient & ~ORIENT_MIRROR, id};
  endfunction

  function automatic logic [2:0] reverse(input logic [2:0] orient);
    case (orient)
      ORIENT_RIGHT: return ORIENT_LEFT;
      ORIENT_LEFT:  return ORIENT_RIGHT;
      ORIENT_DOWN:  return ORIENT_UP;
      default:      return ORIENT_DOWN;
    endcase
  endfunction

endpackage

// File: rtl/ghost_mover_if.sv
// Map-port bundle between a sprite mover (master) and the map arbiter (slave).
interface ghost_mover_if #(parameter int COORD_W = 6) ();
  logic [2*COORD_W-1:0] position;
  logic [7:0]           sprite_read;
  logic [7:0]           sprite_write;
  logic                 ready;
  logic                 read;
  logic                 write;

  modport master (output position, sprite_write, read, write, input sprite_read, ready);
  modport slave  (input position, sprite_write, read, write, output sprite_read, ready);
endinterface

// File: rtl/ghost_mover_frame_divider.sv
// Frame rising-edge detector plus modulo-FRAMES_PER_STEP counter; emits a 1-clk step.
module frame_divider #(
  parameter int FRAMES_PER_STEP = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic frame,
  input  logic activate,
  output logic step
);
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic             frame_q;
  logic             frame_edge;
  logic [CNT_W-1:0] cnt;

  assign frame_edge = frame & ~frame_q;

  // Counting runs regardless of activate so stepping stays phase-locked to frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= 1'b0;
      cnt     <= '0;
      step    <= 1'b0;
    end else begin
      frame_q <= frame;
      step    <= 1'b0;
      if (frame_edge) begin
        if (cnt == CNT_W'(FRAMES_PER_STEP - 1)) begin
          cnt  <= '0;
          step <= activate;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/ghost_mover.sv
// Autonomous patrol mover: probes the next cell on its axis, moves into blanks,
// turns around at bounds or obstacles, and redraws itself through the map port.
module ghost_mover
  import ghost_pkg::*;
#(
  parameter int         COORD_W         = 6,
  parameter int         START_X         = 12,
  parameter int         START_Y         = 4,
  parameter int         MIN_C           = 8,
  parameter int         MAX_C           = 28,
  parameter int         AXIS            = 0,
  parameter int         FRAMES_PER_STEP = 26,
  parameter logic [4:0] SPRITE_ID       = 5'd1,
  parameter logic [7:0] BLANK_CODE      = 8'd0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame,
  input  logic          activate,
  output logic          busy,
  ghost_mover_if.master map
);
  localparam int CW1 = COORD_W + 1;

  logic [COORD_W-1:0]   x, y, tgt;
  logic [2:0]           orient, state;
  logic                 step, pending, req, fwd, in_range;
  logic [CW1-1:0]       cur_ext, nxt_ext;
  logic [2*COORD_W-1:0] tgt_pos;

  frame_divider #(.FRAMES_PER_STEP(FRAMES_PER_STEP)) u_div (
    .clk      (clk),
    .reset    (reset),
    .frame    (frame),
    .activate (activate),
    .step     (step)
  );

  assign req  = map.read | map.write;
  assign busy = (state != ST_IDLE);
  assign fwd  = (orient == ORIENT_RIGHT) || (orient == ORIENT_DOWN);

  // One extra bit keeps 0-1 and max+1 from wrapping back into the legal range.
  assign cur_ext  = {1'b0, (AXIS == 0) ? x : y};
  assign nxt_ext  = fwd ? cur_ext + CW1'(1) : cur_ext - CW1'(1);
  assign in_range = (nxt_ext >= CW1'(MIN_C)) && (nxt_ext <= CW1'(MAX_C));
  assign tgt_pos  = (AXIS == 0) ? {nxt_ext[COORD_W-1:0], y} : {x, nxt_ext[COORD_W-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_INIT;
      x                <= COORD_W'(START_X);
      y                <= COORD_W'(START_Y);
      orient           <= (AXIS == 0) ? ORIENT_RIGHT : ORIENT_DOWN;
      tgt              <= '0;
      pending          <= 1'b0;
      map.read         <= 1'b0;
      map.write        <= 1'b0;
      map.position     <= '0;
      map.sprite_write <= '0;
    end else begin
      // Single-deep step queue; consumed when IDLE launches a probe.
      pending <= step | (pending & (state != ST_IDLE));
      case (state)
        ST_INIT, ST_DRAW: begin
          if (!req) begin
            map.write        <= 1'b1;
            map.position     <= {x, y};
            map.sprite_write <= sprite_code(orient, SPRITE_ID);
          end else if (map.ready) begin
            map.write <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: if (pending) state <= ST_PROBE;
        ST_PROBE: begin
          if (!req) begin
            if (!in_range) begin
              state <= ST_TURN;
            end else begin
              map.read     <= 1'b1;
              map.position <= tgt_pos;
              tgt          <= nxt_ext[COORD_W-1:0];
            end
          end else if (map.ready) begin
            map.read <= 1'b0;
            state    <= (map.sprite_read == BLANK_CODE) ? ST_ERASE : ST_TURN;
          end
        end
        ST_ERASE: begin
          if (!req) begin
            map.write        <= 1'b1;
            map.position     <= {x, y};
            map.sprite_write <= BLANK_CODE;
          end else if (map.ready) begin
            map.write <= 1'b0;
            if (AXIS == 0) x <= tgt;
            else           y <= tgt;
            state <= ST_DRAW;
          end
        end
        ST_TURN: begin
          orient <= reverse(orient);
          state  <= ST_DRAW;
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule
